// File: rtl/bitwise_alu_pipe.sv
// Registered bitwise ALU with valid/ready handshakes, an internal accumulator
// that can stand in for operand y, registered result flags and a saturating command counter.
module bitwise_alu_pipe #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             x,
    input  logic [WIDTH-1:0]             y,
    input  logic [2:0]                   op_code,
    input  logic                         acc_sel,
    input  logic                         acc_clr,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             result,
    output logic                         zero,
    output logic                         parity,
    output logic [$clog2(WIDTH+1)-1:0]   ones,
    output logic [CNT_W-1:0]             op_count
);

    localparam int unsigned ONES_W = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {
        OP_AND  = 3'b000,
        OP_NAND = 3'b001,
        OP_OR   = 3'b010,
        OP_NOR  = 3'b011,
        OP_XOR  = 3'b100,
        OP_XNOR = 3'b101,
        OP_NOTX = 3'b110,
        OP_PASS = 3'b111
    } op_t;

    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] yv;
    logic [WIDTH-1:0] fv;
    logic             accept;

    function automatic logic [ONES_W-1:0] popcount(input logic [WIDTH-1:0] v);
        logic [ONES_W-1:0] cnt;
        cnt = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            cnt = cnt + ONES_W'(v[i]);
        end
        return cnt;
    endfunction

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    always_comb begin
        // A clear in the same cycle overrides the accumulator as operand source
        yv = acc_sel ? (acc_clr ? '0 : acc) : y;
        fv = x;
        case (op_t'(op_code))
            OP_AND:  fv = x & yv;
            OP_NAND: fv = ~(x & yv);
            OP_OR:   fv = x | yv;
            OP_NOR:  fv = ~(x | yv);
            OP_XOR:  fv = x ^ yv;
            OP_XNOR: fv = ~(x ^ yv);
            OP_NOTX: fv = ~x;
            OP_PASS: fv = x;
            default: fv = x;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            result    <= '0;
            zero      <= 1'b1;
            parity    <= 1'b0;
            ones      <= '0;
            out_valid <= 1'b0;
            op_count  <= '0;
            acc       <= '0;
        end else if (accept) begin
            result    <= fv;
            zero      <= (fv == '0);
            parity    <= ^fv;
            ones      <= popcount(fv);
            out_valid <= 1'b1;
            acc       <= fv;
            if (op_count != '1) begin
                op_count <= op_count + CNT_W'(1);
            end
        end else begin
            if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (acc_clr) begin
                acc <= '0;
            end
        end
    end

endmodule

// File: tb/tb_bitwise_alu_pipe.sv
// Directed bench for bitwise_alu_pipe: 8-bit main instance plus a 16-bit
// instance and a 4-bit-counter instance for the parameter boundary cases.
module tb_bitwise_alu_pipe;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    // main instance, WIDTH=8, CNT_W=16
    logic        a_in_valid, a_in_ready, a_acc_sel, a_acc_clr, a_out_valid, a_out_ready;
    logic [7:0]  a_x, a_y, a_result;
    logic [2:0]  a_op;
    logic        a_zero, a_parity;
    logic [3:0]  a_ones;
    logic [15:0] a_op_count;

    // WIDTH=16 instance
    logic        b_in_valid, b_in_ready, b_out_valid;
    logic [15:0] b_x, b_result;
    logic [2:0]  b_op;
    logic        b_zero, b_parity;
    logic [4:0]  b_ones;
    logic [15:0] b_op_count;

    // CNT_W=4 instance
    logic        c_in_valid, c_in_ready, c_out_valid;
    logic [7:0]  c_result;
    logic        c_zero, c_parity;
    logic [3:0]  c_ones;
    logic [3:0]  c_op_count;

    bitwise_alu_pipe #(.WIDTH(8), .CNT_W(16)) u_a (
        .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .x(a_x), .y(a_y), .op_code(a_op), .acc_sel(a_acc_sel), .acc_clr(a_acc_clr),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .result(a_result),
        .zero(a_zero), .parity(a_parity), .ones(a_ones), .op_count(a_op_count)
    );

    bitwise_alu_pipe #(.WIDTH(16), .CNT_W(16)) u_b (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .x(b_x), .y(16'h0000), .op_code(b_op), .acc_sel(1'b0), .acc_clr(1'b0),
        .out_valid(b_out_valid), .out_ready(1'b1), .result(b_result),
        .zero(b_zero), .parity(b_parity), .ones(b_ones), .op_count(b_op_count)
    );

    bitwise_alu_pipe #(.WIDTH(8), .CNT_W(4)) u_c (
        .clk(clk), .rst(rst), .in_valid(c_in_valid), .in_ready(c_in_ready),
        .x(8'h5A), .y(8'h0F), .op_code(3'b100), .acc_sel(1'b0), .acc_clr(1'b0),
        .out_valid(c_out_valid), .out_ready(1'b1), .result(c_result),
        .zero(c_zero), .parity(c_parity), .ones(c_ones), .op_count(c_op_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cmd(input logic v, input logic [7:0] xx, input logic [7:0] yy,
                       input logic [2:0] op, input logic asel, input logic aclr);
        a_in_valid = v;
        a_x        = xx;
        a_y        = yy;
        a_op       = op;
        a_acc_sel  = asel;
        a_acc_clr  = aclr;
    endtask

    task automatic chk_a(input string tag, input logic [7:0] res, input logic z,
                         input logic p, input logic [3:0] n1);
        check({tag, ".valid"},  32'(a_out_valid), 32'd1);
        check({tag, ".result"}, 32'(a_result), 32'(res));
        check({tag, ".zero"},   32'(a_zero), 32'(z));
        check({tag, ".parity"}, 32'(a_parity), 32'(p));
        check({tag, ".ones"},   32'(a_ones), 32'(n1));
    endtask

    initial begin
        rst = 1'b1;
        cmd(1'b0, 8'h00, 8'h00, 3'b000, 1'b0, 1'b0);
        a_out_ready = 1'b1;
        b_in_valid = 1'b0; b_x = '0; b_op = 3'b000;
        c_in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // 1: idle after reset, operand changes without in_valid have no effect
        a_x = 8'hFF; a_y = 8'hFF;
        tick();
        check("rst.out_valid", 32'(a_out_valid), 32'd0);
        check("rst.in_ready",  32'(a_in_ready),  32'd1);
        check("rst.zero",      32'(a_zero),      32'd1);
        check("rst.result",    32'(a_result),    32'd0);
        check("rst.ones",      32'(a_ones),      32'd0);
        check("rst.op_count",  32'(a_op_count),  32'd0);

        // 2: back-to-back, one per cycle
        cmd(1'b1, 8'b00010101, 8'b11000111, 3'b000, 1'b0, 1'b0); tick();
        chk_a("and",  8'h05, 1'b0, 1'b0, 4'd2);
        cmd(1'b1, 8'b00010101, 8'b11000111, 3'b001, 1'b0, 1'b0); tick();
        chk_a("nand", 8'hFA, 1'b0, 1'b0, 4'd6);
        cmd(1'b1, 8'b10010101, 8'b01101111, 3'b010, 1'b0, 1'b0); tick();
        chk_a("or",   8'hFF, 1'b0, 1'b0, 4'd8);
        cmd(1'b1, 8'b10010101, 8'b01101111, 3'b011, 1'b0, 1'b0); tick();
        chk_a("nor",  8'h00, 1'b1, 1'b0, 4'd0);
        cmd(1'b1, 8'b01011001, 8'b01101100, 3'b100, 1'b0, 1'b0); tick();
        chk_a("xor",  8'h35, 1'b0, 1'b0, 4'd4);
        cmd(1'b1, 8'b01101100, 8'b01101100, 3'b101, 1'b0, 1'b0); tick();
        chk_a("xnor", 8'hFF, 1'b0, 1'b0, 4'd8);
        check("b2b.op_count", 32'(a_op_count), 32'd6);
        cmd(1'b0, 8'h00, 8'h00, 3'b000, 1'b0, 1'b0); tick();
        check("drain.out_valid", 32'(a_out_valid), 32'd0);
        check("drain.result",    32'(a_result),    32'hFF);

        // 3: backpressure
        cmd(1'b1, 8'h3C, 8'h0F, 3'b000, 1'b0, 1'b0); tick();
        chk_a("bp.first", 8'h0C, 1'b0, 1'b0, 4'd2);
        a_out_ready = 1'b0;
        cmd(1'b1, 8'hFF, 8'h00, 3'b111, 1'b0, 1'b0);
        #1;
        check("bp.in_ready_low", 32'(a_in_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp.hold_result", 32'(a_result),    32'h0C);
            check("bp.hold_valid",  32'(a_out_valid), 32'd1);
            check("bp.hold_ready",  32'(a_in_ready),  32'd0);
        end
        a_out_ready = 1'b1;
        #1;
        check("bp.in_ready_high", 32'(a_in_ready), 32'd1);
        tick();
        chk_a("bp.second", 8'hFF, 1'b0, 1'b0, 4'd8);
        check("bp.op_count", 32'(a_op_count), 32'd8);
        cmd(1'b0, 8'h00, 8'h00, 3'b000, 1'b0, 1'b0); tick();
        check("bp.drain", 32'(a_out_valid), 32'd0);

        // 4: accumulator (holds 0xFF here, so the clear is observable)
        cmd(1'b0, 8'h00, 8'h00, 3'b000, 1'b0, 1'b1); tick();
        cmd(1'b1, 8'h0F, 8'hA5, 3'b010, 1'b1, 1'b0); tick();
        chk_a("acc.or",  8'h0F, 1'b0, 1'b0, 4'd4);
        cmd(1'b1, 8'hF0, 8'hA5, 3'b100, 1'b1, 1'b0); tick();
        chk_a("acc.xor", 8'hFF, 1'b0, 1'b0, 4'd8);
        cmd(1'b1, 8'h55, 8'h00, 3'b000, 1'b1, 1'b0); tick();
        chk_a("acc.and", 8'h55, 1'b0, 1'b0, 4'd4);

        // 5: clear together with an accepted acc_sel command
        cmd(1'b1, 8'hFF, 8'h00, 3'b111, 1'b0, 1'b0); tick();
        cmd(1'b1, 8'hAA, 8'h00, 3'b010, 1'b1, 1'b1); tick();
        chk_a("clr.same", 8'hAA, 1'b0, 1'b0, 4'd4);
        cmd(1'b1, 8'h00, 8'h00, 3'b010, 1'b1, 1'b0); tick();
        chk_a("clr.next", 8'hAA, 1'b0, 1'b0, 4'd4);
        check("clr.op_count", 32'(a_op_count), 32'd14);
        cmd(1'b0, 8'h00, 8'h00, 3'b000, 1'b0, 1'b0);

        // 6a: WIDTH=16
        b_in_valid = 1'b1; b_x = 16'hFFFF; b_op = 3'b110; tick();
        check("w16.not.result", 32'(b_result), 32'h0000);
        check("w16.not.zero",   32'(b_zero),   32'd1);
        check("w16.not.ones",   32'(b_ones),   32'd0);
        b_op = 3'b111; tick();
        check("w16.pass.result", 32'(b_result), 32'hFFFF);
        check("w16.pass.ones",   32'(b_ones),   32'd16);
        check("w16.pass.zero",   32'(b_zero),   32'd0);
        check("w16.pass.parity", 32'(b_parity), 32'd0);
        b_in_valid = 1'b0;

        // 6b: CNT_W=4 saturation
        c_in_valid = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 14 || i == 15 || i == 20) begin
                check("sat.op_count", 32'(c_op_count), (i < 15) ? 32'(i) : 32'd15);
            end
        end
        check("sat.result", 32'(c_result), 32'h55);
        c_in_valid = 1'b0;

        // 6c: reset with a pending result and a command presented during reset
        a_out_ready = 1'b0;
        cmd(1'b1, 8'h81, 8'h00, 3'b111, 1'b0, 1'b0); tick();
        check("rmid.pending", 32'(a_out_valid), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rmid.out_valid", 32'(a_out_valid), 32'd0);
        check("rmid.result",    32'(a_result),    32'd0);
        check("rmid.zero",      32'(a_zero),      32'd1);
        check("rmid.op_count",  32'(a_op_count),  32'd0);
        cmd(1'b0, 8'h00, 8'h00, 3'b000, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
